// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for one shared multi-cycle FP adder.
// One operation in flight at a time; a stalled adder is aborted after TIMEOUT_CYCLES.
module fp_add_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_result,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_result,
    output logic        rsp1_err,
    output logic [31:0] fpa_x,
    output logic [31:0] fpa_y,
    output logic        fpa_start,
    input  logic        fpa_done,
    input  logic [31:0] fpa_result,
    output logic        busy
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             gid_q, gid_d;
    logic [31:0]      x_q, x_d;
    logic [31:0]      y_q, y_d;
    logic [31:0]      rsp0_result_q, rsp0_result_d;
    logic             rsp0_err_q, rsp0_err_d;
    logic [31:0]      rsp1_result_q, rsp1_result_d;
    logic             rsp1_err_q, rsp1_err_d;

    logic any_valid;
    logic grant_id;
    logic accept;

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        accept     = (state_q == S_IDLE) && any_valid && !reset;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        gid_d         = gid_q;
        x_d           = x_q;
        y_d           = y_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_err_d    = rsp0_err_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_err_d    = rsp1_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    gid_d   = grant_id;
                    x_d     = grant_id ? req1_x : req0_x;
                    y_d     = grant_id ? req1_y : req0_y;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final wait cycle beats the timeout.
                if (fpa_done || cnt_q == CNT_LAST) begin
                    if (gid_q) begin
                        rsp1_result_d = fpa_done ? fpa_result : QNAN;
                        rsp1_err_d    = !fpa_done;
                    end else begin
                        rsp0_result_d = fpa_done ? fpa_result : QNAN;
                        rsp0_err_d    = !fpa_done;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                last_grant_d = gid_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_grant_q  <= 1'b1;
            gid_q         <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            rsp0_result_q <= '0;
            rsp0_err_q    <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            gid_q         <= gid_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_err_q    <= rsp0_err_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_err_q    <= rsp1_err_d;
        end
    end

    // Pulses are masked by reset so an abort never leaks a start or response.
    assign fpa_x       = x_q;
    assign fpa_y       = y_q;
    assign fpa_start   = (state_q == S_ISSUE) && !reset;
    assign busy        = (state_q != S_IDLE);
    assign rsp0_valid  = (state_q == S_RESP) && !gid_q && !reset;
    assign rsp1_valid  = (state_q == S_RESP) && gid_q && !reset;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_err    = rsp0_err_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_err    = rsp1_err_q;

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before an operation is aborted.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1: requester N presents operands.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1: block accepts requester N this cycle.
REQ-006 The block SHALL have ports req0_x, req0_y, req1_x, req1_y, input, 32: IEEE-754 single-precision operands.
REQ-007 The block SHALL have ports rsp0_valid / rsp1_valid, output, 1: one-cycle result pulse to requester N.
REQ-008 The block SHALL have ports rsp0_result / rsp1_result, output, 32: sum for requester N.
REQ-009 The block SHALL have ports rsp0_err / rsp1_err, output, 1: the operation timed out.
REQ-010 The block SHALL have ports fpa_x, fpa_y, output, 32: operands driven to the shared floating-point adder.
REQ-011 The block SHALL have port fpa_start, output, 1: one-cycle launch pulse to the adder.
REQ-012 The block SHALL have ports fpa_done, input, 1, and fpa_result, input, 32: adder completion and sum.
REQ-013 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with exactly one operation outstanding.
REQ-015 In IDLE, reqN_ready SHALL be driven combinationally high only for the requester granted this cycle; in all other states both ready outputs SHALL be 0.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not equal to last_grant; with one valid, grant that one.
REQ-017 On the edge where valid&ready, the block SHALL capture x, y and the grant id into registers and go to ISSUE.
REQ-018 fpa_x and fpa_y SHALL hold the captured operands from capture until the next capture, and SHALL ignore later changes on the request inputs.
REQ-019 In ISSUE, fpa_start SHALL be high for exactly one cycle, then the FSM SHALL enter WAIT with the wait counter at 0.
REQ-020 In WAIT, fpa_done=1 SHALL capture fpa_result and move the FSM to RESP with err=0.
REQ-021 In WAIT with fpa_done=0, the counter SHALL increment; once it reaches TIMEOUT_CYCLES-1 the FSM SHALL move to RESP with err=1 and result 32'h7FC00000.
REQ-022 fpa_done arriving on the same cycle as the timeout SHALL win, giving err=0.
REQ-023 fpa_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-024 In RESP, only the granted requester's rspN_valid SHALL be high, for exactly one cycle; rspN_result and rspN_err SHALL hold their value until that requester's next response; last_grant SHALL update; the FSM SHALL return to IDLE.
REQ-025 Latency SHALL be: accept at edge k, fpa_start high in cycle k+1, done seen in cycle k+1+L, rsp_valid high in the following cycle.
REQ-026 A new request SHALL be acceptable in the cycle immediately after RESP.

Reset
REQ-027 While reset=1 at an edge, the state SHALL become IDLE, the counter 0, last_grant=1 (req0 wins first tie), and all outputs 0.
REQ-028 Reset mid-operation SHALL abort the operation with no rsp_valid pulse, and any later fpa_done SHALL be ignored.
REQ-029 Reset SHALL take priority over every other event on the same edge.

Verification
REQ-030 Single add: req0 with 3F800000 + 40000000, adder model with L=3 -> fpa_start one cycle after accept; rsp0_valid 5 cycles after accept; rsp0_result=40400000, rsp0_err=0.
REQ-031 Contention: both valid after reset -> req0 served first; req1 served next; then with both still valid req0 is granted again; neither requester is starved.
REQ-032 Timeout: TIMEOUT_CYCLES=8, adder never sets done -> rsp1_valid with rsp1_err=1 and rsp1_result=7FC00000, busy low the cycle after.
REQ-033 Reset during WAIT, then fpa_done pulsed -> no rsp pulse, block in IDLE, the next request completes normally.
REQ-034 Done collides with the timeout cycle, and req operands change while busy -> err=0; fpa_x and fpa_y stay stable until the next accept.
